pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush, bubble masking of control fields and a saturating stall counter. It generalises the fixed per-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable stage that can stall and flush without external glue logic. Control bits (RegWrite, MemWrite, branch, etc.) are placed on `ctrl` and payload (PC, instruction, ALU result, memory data, register address) on `data`.

---
 rtl/pipe_stage_reg.sv | 161 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush, bubble masking and stall counter
// Optional feature macro: PIPE_STAGE_SKID_EN (main + skid storage with registered in_ready).
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              accept;
  logic              release_beat;

  assign accept       = in_valid && in_ready;
  assign release_beat = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  // bit 0 = main valid, bit 1 = skid valid, so both flags are direct flop outputs
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b01;
  localparam logic [1:0] ST_SKID  = 2'b11;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign out_valid = state[0];
  assign in_ready  = !state[1];

  // next-state and load strobes; flush overrides every other move and loads nothing
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt    = ST_FULL;
            load_main_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && release_beat) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = ST_SKID;
            load_skid = 1'b1;
          end else if (release_beat) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (release_beat) begin
            state_nxt      = ST_FULL;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // storage state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // main and skid payload registers; main refills from skid when the older beat leaves
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end
`else
  logic main_valid;
  logic load_main;

  assign out_valid = main_valid;
  // a held beat leaving this cycle frees the slot for the incoming one
  assign in_ready  = !main_valid || out_ready;
  assign load_main = accept && !flush;

  // single-entry valid flag; flush wins over accept
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      main_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (accept) begin
      main_valid <= 1'b1;
    end else if (release_beat) begin
      main_valid <= 1'b0;
    end
  end

  // payload register only changes when a beat is actually kept
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (load_main) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
    end
  end
`endif

  // bubbles never carry live control bits downstream
  assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};
  assign out_data = main_data;

  // saturating count of cycles where a beat waits on downstream; only reset clears it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized self-checking bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID_BUILD = 1'b1;
`else
  localparam bit SKID_BUILD = 1'b0;
`endif

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] data;
  } beat_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_ctrl;
  logic [31:0] out_data;
  logic [15:0] stall_cnt;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [7:0]  sat_out_ctrl;
  logic [31:0] sat_out_data;
  logic [3:0]  sat_stall_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  beat_t       q[$];
  logic [31:0] m_last;
  int          m_stall;
  int          m_stall_sat;

  always #5 clock = ~clock;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(16)) u_dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(4)) u_sat (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(sat_out_valid),
    .out_ready(out_ready), .out_ctrl(sat_out_ctrl), .out_data(sat_out_data), .stall_cnt(sat_stall_cnt)
  );

  function automatic bit m_valid();
    return q.size() > 0;
  endfunction

  function automatic bit m_in_ready();
    return SKID_BUILD ? (q.size() < 2) : ((q.size() == 0) || out_ready);
  endfunction

  function automatic logic [7:0] m_ctrl();
    return m_valid() ? q[0].ctrl : 8'h00;
  endfunction

  function automatic logic [31:0] m_data();
    return m_valid() ? q[0].data : m_last;
  endfunction

  task automatic model_clear();
    q.delete();
    m_last      = '0;
    m_stall     = 0;
    m_stall_sat = 0;
  endtask

  task automatic drive(input bit v, input logic [7:0] c, input logic [31:0] d, input bit f, input bit r);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    flush     = f;
    out_ready = r;
  endtask

  // one clock edge: the model takes the inputs as they stood at the edge
  task automatic tick();
    bit    acc, rel, stl;
    beat_t b;
    acc    = in_valid && m_in_ready();
    rel    = m_valid() && out_ready;
    stl    = m_valid() && !out_ready;
    b.ctrl = in_ctrl;
    b.data = in_data;
    @(posedge clock);
    if (!resetn) begin
      model_clear();
    end else begin
      if (stl) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall_sat < 15) m_stall_sat++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (rel) void'(q.pop_front());
        if (acc) q.push_back(b);
      end
      if (q.size() > 0) m_last = q[0].data;
    end
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    model_clear();
    drive(1'b1, 8'hFF, 32'hDEADBEEF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #2;
      n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (out_ctrl !== 8'h00) begin n_miss++; $display("FAIL reset_out_ctrl: got %h expected 00", out_ctrl); end
      n_vec++; if (out_data !== 32'h0) begin n_miss++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      n_vec++; if (stall_cnt !== 16'h0) begin n_miss++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
      n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      tick();
    end
    resetn = 1'b1;
    #2;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL post_reset_empty: got %b expected 0", out_valid); end
    tick();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
    #2;
    n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL first_beat_valid: got %b expected 1", out_valid); end
    n_vec++; if (out_data !== 32'hDEADBEEF) begin n_miss++; $display("FAIL first_beat_data: got %h expected deadbeef", out_data); end
    n_vec++; if (out_ctrl !== 8'hFF) begin n_miss++; $display("FAIL first_beat_ctrl: got %h expected ff", out_ctrl); end
    tick();
    #2;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL drain_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_ctrl !== 8'h00) begin n_miss++; $display("FAIL bubble_ctrl: got %h expected 00", out_ctrl); end
    n_vec++; if (out_data !== 32'hDEADBEEF) begin n_miss++; $display("FAIL data_hold: got %h expected deadbeef", out_data); end
  endtask

  task automatic test_saturation();
    int base, sbase, e, es;
    base  = m_stall;
    sbase = m_stall_sat;
    drive(1'b1, 8'h5A, 32'h11, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      #2;
      e  = base + k;
      es = (sbase + k > 15) ? 15 : sbase + k;
      n_vec++; if (stall_cnt !== 16'(e)) begin n_miss++; $display("FAIL stall_cnt_k%0d: got %0d expected %0d", k, stall_cnt, e); end
      n_vec++; if (sat_stall_cnt !== 4'(es)) begin n_miss++; $display("FAIL sat_cnt_k%0d: got %0d expected %0d", k, sat_stall_cnt, es); end
      n_vec++; if (out_data !== 32'h11 || out_valid !== 1'b1) begin n_miss++; $display("FAIL stall_hold_k%0d: got %b/%h expected 1/11", k, out_valid, out_data); end
    end
    out_ready = 1'b1;
    tick();
    #2;
    n_vec++; if (sat_stall_cnt !== 4'd15) begin n_miss++; $display("FAIL sat_held: got %0d expected 15", sat_stall_cnt); end
    n_vec++; if (stall_cnt !== 16'(base + 20)) begin n_miss++; $display("FAIL cnt_after_release: got %0d expected %0d", stall_cnt, base + 20); end
  endtask

  task automatic test_streaming();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
    tick();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'h01, 32'(i), 1'b0, 1'b1);
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL stream_ready_%0d: got %b expected 1", i, in_ready); end
      tick();
      #1;
      n_vec++; if (out_valid !== 1'b1 || out_data !== 32'(i) || out_ctrl !== 8'h01) begin
        n_miss++; $display("FAIL stream_beat_%0d: got %b/%h/%h expected 1/%h/01", i, out_valid, out_data, out_ctrl, i);
      end
    end
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
    tick();
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL stream_end: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int s0, nst;
    s0 = m_stall;
    drive(1'b1, 8'h03, 32'hA, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h03, 32'hB, 1'b0, 1'b0);
    #2;
`ifdef PIPE_STAGE_SKID_EN
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL bp_ready_full: got %b expected 1", in_ready); end
    tick();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #2;
      n_vec++; if (in_ready !== 1'b0 || out_data !== 32'hA) begin n_miss++; $display("FAIL bp_skid_%0d: got %b/%h expected 0/a", i, in_ready, out_data); end
      tick();
    end
    nst = 4;
    out_ready = 1'b1;
    #2;
    n_vec++; if (out_valid !== 1'b1 || out_data !== 32'hA) begin n_miss++; $display("FAIL bp_first: got %b/%h expected 1/a", out_valid, out_data); end
    tick();
    #2;
    n_vec++; if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin
      n_miss++; $display("FAIL bp_second: got %b/%h/%b expected 1/b/1", out_valid, out_data, in_ready);
    end
    tick();
`else
    n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL bp_ready_comb_low: got %b expected 0", in_ready); end
    tick();
    #2;
    n_vec++; if (out_data !== 32'hA) begin n_miss++; $display("FAIL bp_hold: got %h expected a", out_data); end
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL bp_ready_comb_high: got %b expected 1", in_ready); end
    tick();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
    #2;
    n_vec++; if (out_valid !== 1'b1 || out_data !== 32'hB) begin n_miss++; $display("FAIL bp_swap: got %b/%h expected 1/b", out_valid, out_data); end
    tick();
    nst = 1;
`endif
    #2;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
    n_vec++; if (stall_cnt !== 16'(s0 + nst)) begin n_miss++; $display("FAIL bp_stall_cnt: got %0d expected %0d", stall_cnt, s0 + nst); end
  endtask

  task automatic test_flush();
    logic exp_rdy;
    drive(1'b1, 8'h42, 32'h1A, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h42, 32'h1B, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h77, 32'hC, 1'b1, 1'b1);
    #2;
    exp_rdy = SKID_BUILD ? 1'b0 : 1'b1;
    n_vec++; if (in_ready !== exp_rdy) begin n_miss++; $display("FAIL flush_in_ready: got %b expected %b", in_ready, exp_rdy); end
    tick();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
    #2;
    n_vec++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin n_miss++; $display("FAIL flush_bubble: got %b/%h expected 0/00", out_valid, out_ctrl); end
    n_vec++; if (out_data !== 32'h1A) begin n_miss++; $display("FAIL flush_data_kept: got %h expected 1a", out_data); end
    for (int i = 0; i < 4; i++) begin
      tick();
      #2;
      n_vec++; if (out_valid !== 1'b0 || out_data === 32'hC) begin n_miss++; $display("FAIL flush_no_c_%0d: got %b/%h expected 0/not c", i, out_valid, out_data); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!resetn) resetn = 1'b1;
      drive(($urandom % 4) != 0, 8'($urandom), $urandom, ($urandom % 23) == 0, ($urandom % 3) != 0);
      if (($urandom % 97) == 0) begin
        resetn = 1'b0;
        model_clear();
      end
      #2;
      n_vec++; if (out_valid !== m_valid()) begin n_miss++; $display("FAIL rnd_valid_%0d: got %b expected %b", i, out_valid, m_valid()); end
      n_vec++; if (out_ctrl !== m_ctrl()) begin n_miss++; $display("FAIL rnd_ctrl_%0d: got %h expected %h", i, out_ctrl, m_ctrl()); end
      n_vec++; if (out_data !== m_data()) begin n_miss++; $display("FAIL rnd_data_%0d: got %h expected %h", i, out_data, m_data()); end
      n_vec++; if (in_ready !== m_in_ready()) begin n_miss++; $display("FAIL rnd_ready_%0d: got %b expected %b", i, in_ready, m_in_ready()); end
      n_vec++; if (stall_cnt !== 16'(m_stall)) begin n_miss++; $display("FAIL rnd_stall_%0d: got %0d expected %0d", i, stall_cnt, m_stall); end
      n_vec++; if (sat_stall_cnt !== 4'(m_stall_sat)) begin n_miss++; $display("FAIL rnd_sat_%0d: got %0d expected %0d", i, sat_stall_cnt, m_stall_sat); end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_saturation();
    test_streaming();
    test_backpressure();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
